// File: rtl/clk_gate_ctrl.sv
// clk_gate_ctrl
//   Multi-channel clock-gating controller. Each channel has an ON/GATED/WAKE
//   FSM that gates the channel's clock when software disables it or when it
//   has been idle for IDLE_THRESH cycles, restarts it on a wake request and
//   acknowledges once the clock has been running for WAKE_CYCLES cycles.
//   Each gate is a transparent-low enable latch ANDed with CLK.
//
// Ports
//   CLK          free-running source clock
//   RST          asynchronous reset, active-high
//   TEST_EN      scan/test bypass, forces every gate open
//   IDLE_THRESH  idle cycles before auto-gating (0 disables auto-gating)
//   CH_EN        per-channel software enable (0 requests gating)
//   CH_BUSY      per-channel activity, keeps channel on / wakes it
//   CH_REQ       per-channel explicit wake request
//   GATED_CLK    per-channel gated clock
//   CH_ACK       one-cycle pulse when a channel returns to ON after a wake
//   CH_GATED     registered status, 1 while the channel FSM is GATED
module clk_gate_ctrl #(
    parameter int NUM_CH      = 4,
    parameter int IDLE_W      = 8,
    parameter int WAKE_CYCLES = 2
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              TEST_EN,
    input  logic [IDLE_W-1:0] IDLE_THRESH,
    input  logic [NUM_CH-1:0] CH_EN,
    input  logic [NUM_CH-1:0] CH_BUSY,
    input  logic [NUM_CH-1:0] CH_REQ,
    output logic [NUM_CH-1:0] GATED_CLK,
    output logic [NUM_CH-1:0] CH_ACK,
    output logic [NUM_CH-1:0] CH_GATED
);

    localparam int              WC_W    = (WAKE_CYCLES > 1) ? $clog2(WAKE_CYCLES) : 1;
    localparam logic [WC_W-1:0] WC_LOAD = WC_W'(WAKE_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_ON,
        ST_GATED,
        ST_WAKE
    } state_t;

    state_t            r_state    [NUM_CH];
    state_t            w_state_nxt[NUM_CH];
    logic [IDLE_W-1:0] r_idle_cnt [NUM_CH];
    logic [IDLE_W-1:0] w_idle_nxt [NUM_CH];
    logic [WC_W-1:0]   r_wake_cnt [NUM_CH];
    logic [WC_W-1:0]   w_wake_nxt [NUM_CH];

    logic [NUM_CH-1:0] r_en_q;
    logic [NUM_CH-1:0] r_ack;
    logic [NUM_CH-1:0] r_gated;
    logic [NUM_CH-1:0] r_latch;
    logic [NUM_CH-1:0] w_gate_en;

    // Next-state logic, one independent FSM per channel
    always_comb begin
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            w_state_nxt[i] = r_state[i];
            w_idle_nxt[i]  = r_idle_cnt[i];
            w_wake_nxt[i]  = r_wake_cnt[i];
            case (r_state[i])
                ST_ON: begin
                    if (CH_BUSY[i] || CH_REQ[i]) begin
                        w_idle_nxt[i] = '0;
                    end else if (r_idle_cnt[i] != '1) begin
                        w_idle_nxt[i] = r_idle_cnt[i] + 1'b1;
                    end
                    // BUSY/REQ take priority over both gating causes
                    if (!CH_BUSY[i] && !CH_REQ[i] &&
                        (!CH_EN[i] ||
                         ((IDLE_THRESH != '0) && (r_idle_cnt[i] >= IDLE_THRESH)))) begin
                        w_state_nxt[i] = ST_GATED;
                        w_idle_nxt[i]  = '0;
                    end
                end
                ST_GATED: begin
                    w_idle_nxt[i] = '0;
                    if (CH_EN[i] && (CH_REQ[i] || CH_BUSY[i])) begin
                        w_state_nxt[i] = ST_WAKE;
                        w_wake_nxt[i]  = WC_LOAD;
                    end
                end
                ST_WAKE: begin
                    if (r_wake_cnt[i] == '0) begin
                        w_state_nxt[i] = ST_ON;
                    end else begin
                        w_wake_nxt[i] = r_wake_cnt[i] - 1'b1;
                    end
                end
                default: begin
                    w_state_nxt[i] = ST_ON;
                end
            endcase
        end
    end

    // State registers; enable, status and ack are registered from the next state
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                r_state[i]    <= ST_ON;
                r_idle_cnt[i] <= '0;
                r_wake_cnt[i] <= '0;
            end
            r_en_q  <= '1;
            r_ack   <= '0;
            r_gated <= '0;
        end else begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                r_state[i]    <= w_state_nxt[i];
                r_idle_cnt[i] <= w_idle_nxt[i];
                r_wake_cnt[i] <= w_wake_nxt[i];
                r_en_q[i]     <= (w_state_nxt[i] != ST_GATED);
                r_gated[i]    <= (w_state_nxt[i] == ST_GATED);
                r_ack[i]      <= (r_state[i] == ST_WAKE) && (w_state_nxt[i] == ST_ON);
            end
        end
    end

    assign w_gate_en = r_en_q | {NUM_CH{TEST_EN}};

    // Enable latch is transparent only while CLK is low, so the enable can
    // never change during a high phase and GATED_CLK cannot glitch. Reset
    // forces it open so clocks run throughout reset.
    always_latch begin
        if (RST) begin
            r_latch <= '1;
        end else if (!CLK) begin
            r_latch <= w_gate_en;
        end
    end

    assign GATED_CLK = r_latch & {NUM_CH{CLK}};
    assign CH_ACK    = r_ack;
    assign CH_GATED  = r_gated;

endmodule

// File: doc/clk_gate_ctrl.md
Name: clk_gate_ctrl

Overview:
Multi-channel clock-gating controller for per-subsystem power saving. Each channel owns a glitch-free latch-based gate (transparent-low enable latch ANDed with CLK), driven by a per-channel FSM. The FSM gates a channel when software disables it or when the channel has been idle for a programmable number of cycles. It restarts the clock on a wake request and acknowledges once the clock is stable. Sits at the clock root between CLK and each subsystem's clock input.

Parameters:
NUM_CH, 4, number of independently gated channels
IDLE_W, 8, width of the idle counter and of IDLE_THRESH
WAKE_CYCLES, 2, cycles of running clock in WAKE before CH_ACK (min 1)

Ports:
CLK  input  1  free-running source clock
RST  input  1  asynchronous reset, active-high
TEST_EN  input  1  scan/test bypass; forces every gate open
IDLE_THRESH  input  IDLE_W  idle cycles before auto-gating; 0 disables auto-gating
CH_EN  input  NUM_CH  per-channel software enable; 0 requests gating
CH_BUSY  input  NUM_CH  channel activity; keeps the channel on and can wake it
CH_REQ  input  NUM_CH  explicit wake request
GATED_CLK  output  NUM_CH  gated clock per channel
CH_ACK  output  NUM_CH  1-cycle pulse when the channel returns to ON after a wake
CH_GATED  output  NUM_CH  registered status; 1 while the FSM is in GATED

Behaviour:
- Per-channel FSM states: ON, GATED, WAKE. Channels are fully independent.
- Per-channel registers: idle_cnt[IDLE_W], wake_cnt, en_q. en_q = 1 in ON and WAKE, 0 in GATED. en_q is registered on posedge CLK.
- Gate: latch transparent while CLK=0, input = en_q | TEST_EN. GATED_CLK = latch_out & CLK. No glitches or truncated high pulses on any GATED_CLK.
- Reset (async, RST=1): state=ON, idle_cnt=0, wake_cnt=0, en_q=1, CH_ACK=0, CH_GATED=0. Latch output forced to 1 asynchronously, so GATED_CLK follows CLK during and after reset.
- ON state:
  - If CH_BUSY | CH_REQ: idle_cnt<=0.
  - Otherwise idle_cnt increments, saturating at all-ones.
  - Go to GATED at the next posedge when CH_BUSY=0, CH_REQ=0, and either CH_EN=0 or (IDLE_THRESH!=0 and idle_cnt>=IDLE_THRESH).
  - Priority: BUSY/REQ beat both gating conditions in the same cycle (stay ON, clear idle_cnt).
- GATED state:
  - idle_cnt held at 0.
  - If CH_EN=1 and (CH_REQ | CH_BUSY): go to WAKE and load wake_cnt=WAKE_CYCLES-1.
  - If CH_EN=0: stay GATED regardless of REQ/BUSY.
- WAKE state:
  - If wake_cnt==0: go to ON and assert CH_ACK for exactly one cycle, registered in the cycle the state becomes ON.
  - Otherwise wake_cnt decrements.
  - CH_REQ, CH_BUSY and CH_EN are ignored in WAKE.
  - If CH_EN drops during WAKE, the wake completes; gating then follows the ON rules.
- Latency, with state change at posedge k:
  - Entering GATED: last GATED_CLK high pulse is cycle k; no pulse from posedge k+1.
  - Entering WAKE: first GATED_CLK pulse at posedge k+1.
  - CH_ACK rises WAKE_CYCLES cycles after entry to WAKE.
- CH_GATED = 1 exactly while the state is GATED. It reflects FSM state even under TEST_EN.
- TEST_EN=1: all GATED_CLK = CLK; FSMs keep running normally.
- IDLE_THRESH may change at any time. The comparison uses the current value (>=), so lowering it below idle_cnt gates on the next idle cycle.
- RST asserted mid-WAKE or in GATED: immediate return to ON, clock running, no CH_ACK.

Test Plan:
- Reset release, IDLE_THRESH=0, all CH_EN=1, BUSY=0 for 50 cycles -> every GATED_CLK toggles with CLK, CH_GATED=0, CH_ACK never asserts.
- IDLE_THRESH=5, ch0 idle from reset -> ch0 enters GATED after idle_cnt reaches 5, CH_GATED[0]=1, GATED_CLK[0] flat low from the following posedge; other channels with BUSY=1 keep running.
- Ch0 gated, pulse CH_REQ[0] one cycle, WAKE_CYCLES=2 -> GATED_CLK[0] resumes next posedge, CH_ACK[0] pulses 2 cycles after WAKE entry, CH_GATED[0]=0.
- Ch1 CH_EN=0 with BUSY=1 for 3 cycles then BUSY=0 -> stays ON during busy, gates one cycle after BUSY falls. A CH_REQ[1] while CH_EN=0 leaves it GATED.
- Same cycle idle_cnt==IDLE_THRESH and CH_REQ=1 -> stays ON, idle_cnt clears, no gating. TEST_EN=1 with ch2 GATED -> GATED_CLK[2]=CLK and CH_GATED[2] stays 1.
- RST asserted mid-WAKE (wake_cnt=1) -> all channels ON, GATED_CLK running immediately, no CH_ACK pulse. Glitch check: no GATED_CLK high pulse shorter than CLK high phase anywhere.
